// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one data-memory port between fetch (F) and load/store (L)
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   f_req/f_addr                   fetch read request (held until f_gnt)
//   f_gnt/f_rvalid/f_rdata         fetch grant pulse, read-data valid pulse, read data
//   l_req/l_we/l_addr/l_wdata      load/store request (held until l_gnt)
//   l_gnt/l_rvalid/l_rdata         load/store grant pulse, read-data valid pulse, read data
//   m_addr/m_wd/m_mw/m_mr/m_rd     memory address, write data, write/read strobes, read data
//   busy                           high whenever an access is in progress
module mem_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 15,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [WIDTH-1:0]  f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [WIDTH-1:0]  l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [WIDTH-1:0]  l_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [WIDTH-1:0]  m_wd,
  output logic              m_mw,
  output logic              m_mr,
  input  logic [WIDTH-1:0]  m_rd,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic last_l_q, last_l_d, win_l_q, win_l_d;
  logic [3:0] cnt_q, cnt_d;
  logic f_gnt_q, f_gnt_d, l_gnt_q, l_gnt_d, mr_q, mr_d, mw_q, mw_d;
  logic f_rv_q, f_rv_d, l_rv_q, l_rv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wd_q, wd_d, f_rd_q, f_rd_d, l_rd_q, l_rd_d;
  logic pick_l, pick_we;
  // L wins when it is the only requester, or on contention when F was granted last
  assign pick_l  = l_req & (~f_req | ~last_l_q);
  assign pick_we = pick_l & l_we;
  always_comb begin
    state_d  = state_q;
    last_l_d = last_l_q;
    win_l_d  = win_l_q;
    cnt_d    = cnt_q;
    f_gnt_d  = 1'b0;
    l_gnt_d  = 1'b0;
    mr_d     = 1'b0;
    mw_d     = 1'b0;
    f_rv_d   = 1'b0;
    l_rv_d   = 1'b0;
    addr_d   = addr_q;
    wd_d     = wd_q;
    f_rd_d   = f_rd_q;
    l_rd_d   = l_rd_q;
    case (state_q)
      IDLE: if (f_req | l_req) begin
        state_d  = ISSUE;
        last_l_d = pick_l;
        win_l_d  = pick_l;
        f_gnt_d  = ~pick_l;
        l_gnt_d  = pick_l;
        mr_d     = ~pick_we;
        mw_d     = pick_we;
        addr_d   = pick_l ? l_addr : f_addr;
        wd_d     = pick_we ? l_wdata : wd_q;
      end
      // mw_q is still high during ISSUE, so it tells a write from a read here
      ISSUE: begin
        state_d = mw_q ? IDLE : WAIT;
        cnt_d   = 4'(LAT - 1);
      end
      // the last WAIT cycle is exactly LAT cycles after ISSUE, when m_rd is valid
      WAIT: if (cnt_q == 4'd0) begin
        state_d = RESP;
        f_rv_d  = ~win_l_q;
        l_rv_d  = win_l_q;
        f_rd_d  = win_l_q ? f_rd_q : m_rd;
        l_rd_d  = win_l_q ? m_rd : l_rd_q;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_l_q <= 1'b1;
      win_l_q  <= 1'b0;
      cnt_q    <= '0;
      f_gnt_q  <= 1'b0;
      l_gnt_q  <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      f_rv_q   <= 1'b0;
      l_rv_q   <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      f_rd_q   <= '0;
      l_rd_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_l_q <= last_l_d;
      win_l_q  <= win_l_d;
      cnt_q    <= cnt_d;
      f_gnt_q  <= f_gnt_d;
      l_gnt_q  <= l_gnt_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      f_rv_q   <= f_rv_d;
      l_rv_q   <= l_rv_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      f_rd_q   <= f_rd_d;
      l_rd_q   <= l_rd_d;
    end
  end
  assign f_gnt    = f_gnt_q;
  assign l_gnt    = l_gnt_q;
  assign f_rvalid = f_rv_q;
  assign l_rvalid = l_rv_q;
  assign f_rdata  = f_rd_q;
  assign l_rdata  = l_rd_q;
  assign m_addr   = addr_q;
  assign m_wd     = wd_q;
  assign m_mr     = mr_q;
  assign m_mw     = mw_q;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter against a transaction-timeline reference model
module tb_mem_arbiter;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 15;
  localparam int LAT    = 2;
  localparam int NCYC   = 3000;
  localparam int NC     = NCYC + LAT + 8;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              f_req = 1'b0;
  logic [ADDR_W-1:0] f_addr = '0;
  logic              f_gnt, f_rvalid;
  logic [WIDTH-1:0]  f_rdata;
  logic              l_req = 1'b0;
  logic              l_we = 1'b0;
  logic [ADDR_W-1:0] l_addr = '0;
  logic [WIDTH-1:0]  l_wdata = '0;
  logic              l_gnt, l_rvalid;
  logic [WIDTH-1:0]  l_rdata;
  logic [ADDR_W-1:0] m_addr;
  logic [WIDTH-1:0]  m_wd;
  logic              m_mw, m_mr;
  logic [WIDTH-1:0]  m_rd = '0;
  logic              busy;
  logic [6:0]        ctl;
  mem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_addr(m_addr), .m_wd(m_wd), .m_mw(m_mw), .m_mr(m_mr), .m_rd(m_rd), .busy(busy)
  );
  always #5 clk = ~clk;
  // ctl bits: 6 f_gnt, 5 l_gnt, 4 m_mr, 3 m_mw, 2 f_rvalid, 1 l_rvalid, 0 busy
  assign ctl = {f_gnt, l_gnt, m_mr, m_mw, f_rvalid, l_rvalid, busy};
  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [ADDR_W-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    return r == 0 ? {ADDR_W{1'b1}} : r < 3 ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
  endfunction
  logic [WIDTH-1:0]  mem     [1<<ADDR_W];
  logic [WIDTH-1:0]  ref_mem [1<<ADDR_W];
  logic [6:0]        e_ctl   [NC];
  logic [ADDR_W-1:0] e_addr  [NC];
  logic [WIDTH-1:0]  e_wd    [NC];
  logic [WIDTH-1:0]  e_rd    [NC];
  initial begin
    int rd_cycle, free_at, fr_issue, p;
    logic [WIDTH-1:0] rd_data, f_hold, l_hold;
    logic [ADDR_W-1:0] a;
    bit last_l, fs, ls, wl, we, rst_now, did_wait_rst;
    rd_cycle = -1; free_at = 0; fr_issue = -10; last_l = 1'b1;
    fs = 1'b0; ls = 1'b0; did_wait_rst = 1'b0; rd_data = '0; f_hold = '0; l_hold = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int k = 0; k < NC; k++) begin
      e_ctl[k] = '0; e_addr[k] = '0; e_wd[k] = '0; e_rd[k] = '0;
    end
    #3;
    check("reset_ctl", 64'(ctl), 64'd0);
    check("reset_mem", 64'({m_addr, m_wd}), 64'd0);
    check("reset_rdata", {f_rdata, l_rdata}, 64'd0);
    @(posedge clk); #1;
    for (int c = 0; c < NCYC; c++) begin
      rst = 1'b0;
      m_rd = (c == rd_cycle) ? rd_data : $urandom;
      check("ctl", 64'(ctl), 64'(e_ctl[c]));
      if (e_ctl[c][4] | e_ctl[c][3]) check("m_addr", 64'(m_addr), 64'(e_addr[c]));
      if (e_ctl[c][3]) check("m_wd", 64'(m_wd), 64'(e_wd[c]));
      if (e_ctl[c][2]) f_hold = e_rd[c];
      if (e_ctl[c][1]) l_hold = e_rd[c];
      check("f_rdata", 64'(f_rdata), 64'(f_hold));
      check("l_rdata", 64'(l_rdata), 64'(l_hold));
      if (m_mr) begin
        rd_cycle = c + LAT;
        rd_data = mem[m_addr];
      end
      if (m_mw) mem[m_addr] = m_wd;
      if (fs) f_req = 1'b0;
      if (ls) l_req = 1'b0;
      fs = f_gnt;
      ls = l_gnt;
      p = c < 200 ? 100 : 35;
      if (!f_req && $urandom_range(0, 99) < p) begin
        f_req = 1'b1;
        f_addr = rand_addr();
      end
      if (!l_req && $urandom_range(0, 99) < p) begin
        l_req = 1'b1;
        l_addr = rand_addr();
        l_we = c < 200 ? 1'b0 : 1'($urandom);
        l_wdata = $urandom;
      end
      rst_now = 1'b0;
      if (c >= 300 && !did_wait_rst && c == fr_issue + 1) begin
        rst_now = 1'b1;
        did_wait_rst = 1'b1;
      end
      if (c >= 210 && $urandom_range(0, 149) == 0) rst_now = 1'b1;
      if (rst_now) begin
        rst = 1'b1;
        #1;
        check("arst_ctl", 64'(ctl), 64'd0);
        check("arst_mem", 64'({m_addr, m_wd}), 64'd0);
        check("arst_rdata", {f_rdata, l_rdata}, 64'd0);
        f_hold = '0; l_hold = '0; last_l = 1'b1; free_at = c + 1;
        for (int k = c + 1; k < NC; k++) e_ctl[k] = '0;
      end else if (c >= free_at && (f_req || l_req)) begin
        wl = l_req && (!f_req || !last_l);
        last_l = wl;
        we = wl && l_we;
        a = wl ? l_addr : f_addr;
        e_ctl[c+1] = {!wl, wl, !we, we, 2'b00, 1'b1};
        e_addr[c+1] = a;
        if (we) begin
          ref_mem[a] = l_wdata;
          e_wd[c+1] = l_wdata;
          free_at = c + 2;
        end else begin
          for (int k = c + 2; k <= c + LAT + 2; k++) e_ctl[k][0] = 1'b1;
          if (wl) e_ctl[c+LAT+2][1] = 1'b1;
          else e_ctl[c+LAT+2][2] = 1'b1;
          e_rd[c+LAT+2] = ref_mem[a];
          free_at = c + LAT + 3;
          if (!wl) fr_issue = c + 1;
        end
      end
      @(posedge clk); #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
